// File: rtl/cram_dram_sequencer_if.sv
// Bus between the cartridge glue (PHI2, CPU window decode, refresh inhibit)
// and the DRAM sequencer: phase inputs in, DRAM strobes and status out.
interface cram_dram_sequencer_if;
   logic       PHI2;
   logic       CpuSel;
   logic       CpuWr;
   logic       RefInh;
   logic       nRAS;
   logic       nCAS;
   logic       nRWE;
   logic       RAsel;
   logic       DLatch;
   logic [3:0] S;
   logic [2:0] RefPend;
   logic       RefOverflow;

   modport master (output PHI2, CpuSel, CpuWr, RefInh,
                   input  nRAS, nCAS, nRWE, RAsel, DLatch, S, RefPend, RefOverflow);
   modport slave  (input  PHI2, CpuSel, CpuWr, RefInh,
                   output nRAS, nCAS, nRWE, RAsel, DLatch, S, RefPend, RefOverflow);
endinterface

// File: rtl/cram_dram_sequencer.sv
// DotClk-domain DRAM sequencer locked to PHI2: CAS-before-RAS refresh in the
// PHI2-low half, one CPU access in the PHI2-high half, queued refresh debt.
module cram_dram_sequencer #(
   parameter int REF_INTERVAL = 8,
   parameter int REF_PEND_MAX = 7
) (
   input  logic                  DotClk,
   input  logic                  RES,
   cram_dram_sequencer_if.slave  bus
);
   localparam int DIV_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REF_INTERVAL - 1);
   localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [2:0]       PEND_MAX = 3'(REF_PEND_MAX);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      REF_CAS  = 3'd1,
      REF_RAS  = 3'd2,
      REF_HOLD = 3'd3,
      PRE      = 3'd4,
      ACC_RAS  = 3'd5,
      ACC_MUX  = 3'd6,
      ACC_CAS  = 3'd7
   } state_t;

   // Strobe image {nRAS, nCAS, nRWE, RAsel, DLatch} that each state presents.
   function automatic logic [4:0] strobesFor(input state_t st, input logic wr);
      logic [4:0] o;
      o = 5'b11100;
      case (st)
         REF_CAS:  o = 5'b10100;
         REF_RAS:  o = 5'b00100;
         REF_HOLD: o = 5'b01100;
         ACC_RAS:  o = 5'b01100;
         ACC_MUX:  o = {2'b01, ~wr, 2'b10};
         ACC_CAS:  o = {2'b00, ~wr, 1'b1, ~wr};
         default:  o = 5'b11100;
      endcase
      return o;
   endfunction

   logic             phi2_r;
   logic             seen_r;
   logic [3:0]       phase_r;
   logic [DIV_W-1:0] divCnt_r;
   logic [2:0]       refPend_r;
   logic             refOverflow_r;
   state_t           state_r;
   logic             wr_r;
   logic [4:0]       strobes_r;

   logic fall_s, refReq_s, seqFree_s, refStart_s, accStart_s, refInc_s;

   assign fall_s     = phi2_r & ~bus.PHI2;
   assign refReq_s   = fall_s & (divCnt_r == DIV_LAST);
   assign refInc_s   = refReq_s & (refPend_r != PEND_MAX);
   assign seqFree_s  = (state_r == IDLE) | (state_r == PRE);
   assign refStart_s = seqFree_s & (phase_r == 4'd1) & (refPend_r != 3'd0) & ~bus.RefInh;
   assign accStart_s = seqFree_s & (phase_r == 4'd5) & bus.CpuSel;

   // Phase counter: restarts at 1 on each PHI2 fall, parks at 0 or 15.
   always_ff @(posedge DotClk) begin
      if (RES) begin
         phi2_r  <= 1'b0;
         seen_r  <= 1'b0;
         phase_r <= 4'd0;
      end else begin
         phi2_r <= bus.PHI2;
         seen_r <= seen_r | ~bus.PHI2;
         if (fall_s & seen_r) begin
            phase_r <= 4'd1;
         end else if ((phase_r != 4'd0) && (phase_r != 4'd15)) begin
            phase_r <= phase_r + 4'd1;
         end else begin
            phase_r <= phase_r;
         end
      end
   end

   // Refresh divider and debt counter; an increment and a start cancel out.
   always_ff @(posedge DotClk) begin
      if (RES) begin
         divCnt_r      <= DIV_ZERO;
         refPend_r     <= 3'd0;
         refOverflow_r <= 1'b0;
      end else begin
         if (fall_s) begin
            divCnt_r <= refReq_s ? DIV_ZERO : (divCnt_r + DIV_ONE);
         end else begin
            divCnt_r <= divCnt_r;
         end
         if (refReq_s && (refPend_r == PEND_MAX)) begin
            refOverflow_r <= 1'b1;
         end else begin
            refOverflow_r <= refOverflow_r;
         end
         case ({refInc_s, refStart_s})
            2'b10:   refPend_r <= refPend_r + 3'd1;
            2'b01:   refPend_r <= refPend_r - 3'd1;
            default: refPend_r <= refPend_r;
         endcase
      end
   end

   // Sequencer FSM; strobes are registered alongside the state they belong to.
   always_ff @(posedge DotClk) begin
      if (RES) begin
         state_r   <= IDLE;
         wr_r      <= 1'b0;
         strobes_r <= 5'b11100;
      end else begin
         case (state_r)
            IDLE, PRE: begin
               if (refStart_s) begin
                  state_r   <= REF_CAS;
                  strobes_r <= strobesFor(REF_CAS, wr_r);
               end else if (accStart_s) begin
                  state_r   <= ACC_RAS;
                  wr_r      <= bus.CpuWr;
                  strobes_r <= strobesFor(ACC_RAS, bus.CpuWr);
               end else begin
                  state_r   <= IDLE;
                  strobes_r <= strobesFor(IDLE, wr_r);
               end
            end
            REF_CAS: begin
               state_r   <= REF_RAS;
               strobes_r <= strobesFor(REF_RAS, wr_r);
            end
            REF_RAS: begin
               state_r   <= REF_HOLD;
               strobes_r <= strobesFor(REF_HOLD, wr_r);
            end
            ACC_RAS: begin
               state_r   <= ACC_MUX;
               strobes_r <= strobesFor(ACC_MUX, wr_r);
            end
            ACC_MUX: begin
               state_r   <= ACC_CAS;
               strobes_r <= strobesFor(ACC_CAS, wr_r);
            end
            REF_HOLD, ACC_CAS: begin
               state_r   <= PRE;
               strobes_r <= strobesFor(PRE, wr_r);
            end
            default: begin
               state_r   <= IDLE;
               strobes_r <= strobesFor(IDLE, wr_r);
            end
         endcase
      end
   end

   assign {bus.nRAS, bus.nCAS, bus.nRWE, bus.RAsel, bus.DLatch} = strobes_r;
   assign bus.S           = phase_r;
   assign bus.RefPend     = refPend_r;
   assign bus.RefOverflow = refOverflow_r;
endmodule

// File: tb/tb_cram_dram_sequencer.sv
// Self-checking bench for cram_dram_sequencer: directed scenarios plus random
// traffic, compared against a schedule-level model of the sequencer.
module tb_cram_dram_sequencer;
   localparam int REF_INTERVAL = 8;
   localparam int REF_PEND_MAX = 7;
   localparam logic [4:0] IDLE_O = 5'b11100;

   logic DotClk = 1'b0;
   logic RES    = 1'b0;

   cram_dram_sequencer_if bus();

   cram_dram_sequencer #(.REF_INTERVAL(REF_INTERVAL), .REF_PEND_MAX(REF_PEND_MAX)) dut (
      .DotClk (DotClk),
      .RES    (RES),
      .bus    (bus)
   );

   always #5 DotClk = ~DotClk;

   int checks   = 0;
   int failures = 0;

   // Model: phase tracking from PHI2 samples and a queue of upcoming strobe images.
   logic [3:0] mS    = 4'd0;
   logic       mPrev = 1'b0;
   logic       mSeen = 1'b0;
   logic       mOvf  = 1'b0;
   int         mDiv  = 0;
   int         mPend = 0;
   logic [4:0] mOut  = IDLE_O;
   logic [4:0] sched[$];

   int phiPos  = 0;
   int lowLen  = 4;
   int highLen = 4;
   bit phiHold = 1'b0;
   bit phiRand = 1'b0;

   function automatic logic [12:0] dutVec();
      return {bus.nRAS, bus.nCAS, bus.nRWE, bus.RAsel, bus.DLatch, bus.S, bus.RefPend, bus.RefOverflow};
   endfunction

   function automatic logic [12:0] modelVec();
      return {mOut, mS, 3'(mPend), mOvf};
   endfunction

   task automatic model_step();
      bit fall, free, rStart, aStart;
      if (RES) begin
         mS = 4'd0; mPrev = 1'b0; mSeen = 1'b0; mDiv = 0; mPend = 0; mOvf = 1'b0;
         sched.delete();
         mOut = IDLE_O;
         return;
      end
      fall   = mPrev && !bus.PHI2;
      free   = (sched.size() == 0);
      rStart = free && (mS == 4'd1) && (mPend != 0) && !bus.RefInh;
      aStart = free && (mS == 4'd5) && bus.CpuSel;
      if (rStart) begin
         sched.push_back(5'b10100); sched.push_back(5'b00100);
         sched.push_back(5'b01100); sched.push_back(IDLE_O);
      end else if (aStart) begin
         sched.push_back(5'b01100);
         sched.push_back({2'b01, ~bus.CpuWr, 2'b10});
         sched.push_back({2'b00, ~bus.CpuWr, 1'b1, ~bus.CpuWr});
         sched.push_back(IDLE_O);
      end
      mOut = (sched.size() != 0) ? sched.pop_front() : IDLE_O;
      if (fall && mSeen) mS = 4'd1;
      else if (mS != 4'd0 && mS != 4'd15) mS = mS + 4'd1;
      mPrev = bus.PHI2;
      if (!bus.PHI2) mSeen = 1'b1;
      if (fall) begin
         mDiv = mDiv + 1;
         if (mDiv == REF_INTERVAL) begin
            mDiv = 0;
            if (mPend == REF_PEND_MAX) mOvf = 1'b1;
            else mPend = mPend + 1;
         end
      end
      if (rStart) mPend = mPend - 1;
   endtask

   task automatic cycle();
      @(posedge DotClk);
      model_step();
      #1;
      if (phiHold) begin
         bus.PHI2 = 1'b1;
      end else begin
         phiPos++;
         if (phiPos >= lowLen + highLen) begin
            phiPos = 0;
            if (phiRand) highLen = $urandom_range(2, 6);
         end
         bus.PHI2 = (phiPos >= lowLen);
      end
   endtask

   task automatic do_reset();
      RES = 1'b1; phiPos = 0; bus.PHI2 = 1'b0;
      cycle();
      RES = 1'b0;
   endtask

   task automatic test_reset();
      bus.CpuSel = 1'b1; bus.CpuWr = 1'b1; bus.RefInh = 1'b0;
      do_reset();
      bus.CpuSel = 1'b0; bus.CpuWr = 1'b0;
      checks++;
      if (dutVec() !== {IDLE_O, 4'd0, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_state got=%b want=%b", dutVec(), {IDLE_O, 4'd0, 3'd0, 1'b0});
      end
   endtask

   task automatic test_refresh();
      int falls = 0, n = 0;
      logic [3:0] lastS = 4'd0;
      logic [1:0] refExp [4];
      refExp = '{2'b10, 2'b00, 2'b01, 2'b11};
      while (bus.RefPend == 3'd0 && n < 200) begin
         cycle(); n++;
         if (bus.S == 4'd1 && lastS != 4'd1) falls++;
         lastS = bus.S;
      end
      checks++;
      if (falls != REF_INTERVAL || bus.RefPend !== 3'd1) begin
         failures++;
         $display("FAIL refresh_request falls=%0d pend=%0d want falls=%0d pend=1", falls, bus.RefPend, REF_INTERVAL);
      end
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks++;
         if ({bus.nRAS, bus.nCAS} !== refExp[i] || bus.S !== 4'(i + 2) || bus.RefPend !== 3'd0) begin
            failures++;
            $display("FAIL refresh_seq S=%0d nRAS/nCAS=%b pend=%0d want S=%0d %b pend=0",
                     bus.S, {bus.nRAS, bus.nCAS}, bus.RefPend, i + 2, refExp[i]);
         end
      end
   endtask

   task automatic test_access(input logic wr);
      int n = 0;
      logic [4:0] accExp [4];
      accExp = '{5'b01100, {2'b01, ~wr, 2'b10}, {2'b00, ~wr, 1'b1, ~wr}, IDLE_O};
      while (bus.S != 4'd5 && n < 40) begin cycle(); n++; end
      bus.CpuSel = 1'b1; bus.CpuWr = wr;
      for (int i = 0; i < 4; i++) begin
         cycle();
         bus.CpuSel = 1'b0; bus.CpuWr = ~wr;
         checks++;
         if ({bus.nRAS, bus.nCAS, bus.nRWE, bus.RAsel, bus.DLatch} !== accExp[i] || bus.S !== 4'((i + 6 > 8) ? 1 : i + 6)) begin
            failures++;
            $display("FAIL access_wr%0d S=%0d strobes=%b want=%b", wr, bus.S,
                     {bus.nRAS, bus.nCAS, bus.nRWE, bus.RAsel, bus.DLatch}, accExp[i]);
         end
      end
      bus.CpuWr = 1'b0;
   endtask

   task automatic test_back_to_back();
      int n = 0;
      logic [3:0] b2bExp [7];
      b2bExp = '{4'b1000, 4'b0000, 4'b0100, 4'b1100, 4'b0100, 4'b0110, 4'b0011};
      while (bus.RefPend == 3'd0 && n < 200) begin cycle(); n++; end
      for (int i = 0; i < 7; i++) begin
         bus.CpuSel = (bus.S == 4'd5); bus.CpuWr = 1'b0;
         cycle();
         checks++;
         if ({bus.nRAS, bus.nCAS, bus.RAsel, bus.DLatch} !== b2bExp[i] || dutVec() !== modelVec()) begin
            failures++;
            $display("FAIL back_to_back S=%0d nRAS/nCAS/RAsel/DLatch=%b want=%b", bus.S,
                     {bus.nRAS, bus.nCAS, bus.RAsel, bus.DLatch}, b2bExp[i]);
         end
      end
      bus.CpuSel = 1'b0;
      checks++;
      if (bus.RefPend !== 3'd0) begin
         failures++;
         $display("FAIL back_to_back_pend got=%0d want=0", bus.RefPend);
      end
   endtask

   task automatic test_inhibit_drain();
      int falls = 0, n = 0, refs = 0;
      logic [3:0] lastS = 4'd0;
      bus.RefInh = 1'b1; bus.CpuSel = 1'b0;
      do_reset();
      while (falls < 72 && n < 72 * 8 + 50) begin
         cycle(); n++;
         if (bus.S == 4'd1 && lastS != 4'd1) falls++;
         lastS = bus.S;
      end
      checks++;
      if (falls != 72 || bus.RefPend !== 3'd7 || bus.RefOverflow !== 1'b1) begin
         failures++;
         $display("FAIL inhibit_saturate falls=%0d pend=%0d ovf=%0d want 72 7 1", falls, bus.RefPend, bus.RefOverflow);
      end
      bus.RefInh = 1'b0;
      for (int i = 0; i < 56; i++) begin
         cycle();
         if (bus.nCAS == 1'b0 && bus.nRAS == 1'b1) refs++;
         checks++;
         if (dutVec() !== modelVec()) begin
            failures++;
            $display("FAIL drain_model cyc=%0d got=%b want=%b", i, dutVec(), modelVec());
         end
      end
      checks++;
      if (refs != 7 || bus.RefPend !== 3'd0 || bus.RefOverflow !== 1'b1) begin
         failures++;
         $display("FAIL drain refs=%0d pend=%0d ovf=%0d want 7 0 1", refs, bus.RefPend, bus.RefOverflow);
      end
   endtask

   task automatic test_reset_mid_access();
      int n = 0;
      while (bus.S != 4'd5 && n < 40) begin cycle(); n++; end
      bus.CpuSel = 1'b1; bus.CpuWr = 1'b0;
      cycle(); cycle();
      RES = 1'b1;
      cycle();
      RES = 1'b0;
      checks++;
      if (dutVec() !== {IDLE_O, 4'd0, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid_access got=%b want=%b", dutVec(), {IDLE_O, 4'd0, 3'd0, 1'b0});
      end
      n = 0;
      while (bus.S != 4'd1 && n < 40) begin
         cycle(); n++;
         checks++;
         if (bus.nRAS !== 1'b1 || bus.nCAS !== 1'b1) begin
            failures++;
            $display("FAIL quiet_after_reset S=%0d nRAS=%0d nCAS=%0d want 1 1", bus.S, bus.nRAS, bus.nCAS);
         end
      end
      checks++;
      if (bus.S !== 4'd1) begin
         failures++;
         $display("FAIL resync_timeout S=%0d want=1", bus.S);
      end
      bus.CpuSel = 1'b0;
   endtask

   task automatic test_stall();
      phiHold = 1'b1;
      for (int i = 0; i < 24; i++) begin
         bus.CpuSel = (i >= 18);
         cycle();
         checks++;
         if (dutVec() !== modelVec()) begin
            failures++;
            $display("FAIL stall_model cyc=%0d got=%b want=%b", i, dutVec(), modelVec());
         end
      end
      checks++;
      if (bus.S !== 4'd15 || bus.nRAS !== 1'b1) begin
         failures++;
         $display("FAIL stall_park S=%0d nRAS=%0d want S=15 nRAS=1", bus.S, bus.nRAS);
      end
      phiHold = 1'b0; bus.CpuSel = 1'b0;
   endtask

   task automatic test_random();
      phiRand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         bus.CpuSel = ($urandom_range(0, 9) < 4);
         bus.CpuWr  = $urandom_range(0, 1);
         bus.RefInh = ($urandom_range(0, 9) < 3);
         RES        = ($urandom_range(0, 699) == 0);
         cycle();
         checks++;
         if (dutVec() !== modelVec()) begin
            failures++;
            $display("FAIL random cyc=%0d got=%b want=%b", i, dutVec(), modelVec());
         end
      end
      RES = 1'b0; phiRand = 1'b0; highLen = 4;
   endtask

   initial begin
      bus.PHI2 = 1'b0; bus.CpuSel = 1'b0; bus.CpuWr = 1'b0; bus.RefInh = 1'b0;
      test_reset();
      test_refresh();
      test_access(1'b0);
      test_access(1'b1);
      test_back_to_back();
      test_inhibit_drain();
      test_reset_mid_access();
      test_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
